qa_drv_hc_write_arb: RTL
========================

QA_DRV_HC_WRITE_ARB -- requirements
Module: qa_drv_hc_write_arb

Interface
REQ-001 SHALL have parameter N_WRITERS, default 3: number of host-channel write clients, 2..8.
REQ-002 SHALL have parameter HDR_BITS, default 80: width of one client request header, passed through opaquely.
REQ-003 SHALL have parameter DATA_BITS, default 512: cache-line data width.
REQ-004 SHALL have parameter MAX_OUTSTANDING, default 64: maximum number of writes issued but not yet acknowledged; CW = $clog2(MAX_OUTSTANDING+1).
REQ-005 SHALL have port: clk  in  1  clock; all state updates on its rising edge.
REQ-006 SHALL have port: reset_n  in  1  reset, synchronous, active-low.
REQ-007 SHALL have port: c1_alm_full  in  1  memory write channel almost-full.
REQ-008 SHALL have port: wr_rsp_valid  in  1  one write or fence acknowledgement this cycle.
REQ-009 SHALL have port: wr_en_mask  in  N_WRITERS  per-client enable, from CSR.
REQ-010 SHALL have port: req_valid  in  N_WRITERS  client i has a line or fence pending.
REQ-011 SHALL have port: req_hdr  in  N_WRITERS*HDR_BITS  client i header in slice i.
REQ-012 SHALL have port: req_data  in  N_WRITERS*DATA_BITS  client i data in slice i.
REQ-013 SHALL have port: grant  out  N_WRITERS  one-hot-or-zero; client i request accepted this cycle.
REQ-014 SHALL have port: can_issue  out  1  channel able to accept a write this cycle.
REQ-015 SHALL have port: tx_valid  out  1  registered write request to the memory channel.
REQ-016 SHALL have port: tx_hdr  out  HDR_BITS  registered header.
REQ-017 SHALL have port: tx_data  out  DATA_BITS  registered data.
REQ-018 SHALL have port: outstanding  out  CW  current unacknowledged write count.
REQ-019 SHALL have port: rsp_underflow  out  1  sticky error flag.

Function
REQ-020 SHALL compute can_issue combinationally as !c1_alm_full && (outstanding < MAX_OUTSTANDING).
REQ-021 SHALL treat client i as eligible when req_valid[i] && wr_en_mask[i].
REQ-022 SHALL assert grant[i] combinationally in the same cycle only when can_issue is 1 and i is the first eligible client searching upward from rr_ptr with wrap to 0.
REQ-023 SHALL assert at most one grant bit per cycle, and SHALL assert no grant bit when can_issue is 0 or no client is eligible.
REQ-024 SHALL keep a round-robin pointer rr_ptr of width $clog2(N_WRITERS), reset to 0.
REQ-025 SHALL update rr_ptr on a grant to winner+1, or to 0 when the winner is N_WRITERS-1; rr_ptr SHALL be unchanged in cycles with no grant.
REQ-026 SHALL drive tx_valid in cycle t+1 as 1 when a grant occurred in cycle t, else 0, so the fixed latency is one cycle.
REQ-027 SHALL, on a grant in cycle t, register the winner's req_hdr and req_data slices onto tx_hdr and tx_data for cycle t+1.
REQ-028 SHALL hold tx_hdr and tx_data at their previous values when there is no grant.
REQ-029 SHALL leave the request decision to clients: a client holds req_valid, req_hdr and req_data stable until granted and dequeues in its grant cycle.
REQ-030 SHALL pass fence requests through as ordinary headers: each fence consumes one grant and one outstanding slot.
REQ-031 SHALL update outstanding as follows: grant only -> +1; wr_rsp_valid only -> -1; both in the same cycle -> unchanged.
REQ-032 SHALL not wrap outstanding above MAX_OUTSTANDING; this is guaranteed by REQ-020.
REQ-033 SHALL, when wr_rsp_valid arrives while outstanding == 0 with no simultaneous grant, hold outstanding at 0 and set rsp_underflow; rsp_underflow SHALL stay set until reset.
REQ-034 SHALL stop granting in the same cycle that c1_alm_full rises, which bounds post-almost-full issue to the single registered tx_valid already in flight.
REQ-035 SHALL, when wr_en_mask[i] is cleared, never grant client i thereafter, with no effect on tx_valid already registered.

Reset
REQ-036 SHALL, while reset_n == 0 at a clock edge, clear tx_valid, rr_ptr, outstanding and rsp_underflow to 0 and tx_hdr and tx_data to 0.
REQ-037 SHALL force grant to 0 combinationally during reset.
REQ-038 SHALL discard a grant that coincides with a reset edge; no tx_valid follows it.
REQ-039 SHALL not drop tx_valid early when reset is asserted mid-stream, beyond the REQ-036 clear.

Verification
REQ-040 SHALL cover: N_WRITERS=3, all req_valid=1, mask=3'b111, alm_full=0 -> grants 001,010,100,001 on consecutive cycles; tx_valid=1 from the second cycle, with tx_data matching each winner one cycle later.
REQ-041 SHALL cover: MAX_OUTSTANDING=4, no responses, continuous requests -> exactly 4 grants, then can_issue=0 and outstanding=4; one wr_rsp_valid -> one further grant the next cycle.
REQ-042 SHALL cover: alm_full raised in cycle 5 of a stream -> no grant in cycle 5, one tx_valid in cycle 5 from the cycle-4 grant, and grants resume the cycle alm_full falls.
REQ-043 SHALL cover: grant and wr_rsp_valid in the same cycle with outstanding=2 -> outstanding stays 2.
REQ-044 SHALL cover: wr_rsp_valid with outstanding=0 -> outstanding=0 and rsp_underflow=1, held until reset_n pulse clears it.
REQ-045 SHALL cover: mask=3'b101 with all valid -> grants alternate 001,100 and client 1 is never granted; reset mid-stream -> outputs 0 the next cycle and first post-reset grant goes to client 0.

Source files
------------

// File: rtl/qa_drv_hc_write_arb.sv
// rtl/qa_drv_hc_write_arb.sv - round-robin host-channel write arbiter with outstanding-write credit tracking
//
// Ports:
//   clk, reset_n     clock; synchronous active-low reset
//   c1_alm_full      memory write channel almost-full
//   wr_rsp_valid     one write/fence acknowledgement this cycle
//   wr_en_mask       per-client enable
//   req_valid        per-client request pending
//   req_hdr          per-client header, client i in slice i
//   req_data         per-client line data, client i in slice i
//   grant            one-hot-or-zero, combinational accept for the current cycle
//   can_issue        channel can take a write this cycle
//   tx_valid         registered write request toward the memory channel
//   tx_hdr, tx_data  registered header/data of the last winner
//   outstanding      issued-but-unacknowledged write count
//   rsp_underflow    sticky: acknowledgement seen with nothing outstanding
module qa_drv_hc_write_arb #(
    parameter int N_WRITERS       = 3,
    parameter int HDR_BITS        = 80,
    parameter int DATA_BITS       = 512,
    parameter int MAX_OUTSTANDING = 64,
    localparam int CW             = $clog2(MAX_OUTSTANDING + 1),
    localparam int PW             = $clog2(N_WRITERS)
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           c1_alm_full,
    input  logic                           wr_rsp_valid,
    input  logic [N_WRITERS-1:0]           wr_en_mask,
    input  logic [N_WRITERS-1:0]           req_valid,
    input  logic [N_WRITERS*HDR_BITS-1:0]  req_hdr,
    input  logic [N_WRITERS*DATA_BITS-1:0] req_data,
    output logic [N_WRITERS-1:0]           grant,
    output logic                           can_issue,
    output logic                           tx_valid,
    output logic [HDR_BITS-1:0]            tx_hdr,
    output logic [DATA_BITS-1:0]           tx_data,
    output logic [CW-1:0]                  outstanding,
    output logic                           rsp_underflow
);

    logic [N_WRITERS-1:0] eligible;
    logic [PW-1:0]        rr_ptr;
    logic [PW-1:0]        win_idx;
    logic                 win_found;
    logic                 do_grant;
    logic [HDR_BITS-1:0]  sel_hdr;
    logic [DATA_BITS-1:0] sel_data;

    assign eligible  = req_valid & wr_en_mask;
    assign can_issue = !c1_alm_full && (outstanding < CW'(MAX_OUTSTANDING));

    // Round-robin search: first pass looks at clients at or above rr_ptr,
    // second pass picks up the wrap-around (clients below rr_ptr). The
    // second pass only matters when the first found nothing.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 0; i < N_WRITERS; i++) begin
            if (!win_found && eligible[i] && (PW'(i) >= rr_ptr)) begin
                win_found = 1'b1;
                win_idx   = PW'(i);
            end
        end
        for (int i = 0; i < N_WRITERS; i++) begin
            if (!win_found && eligible[i]) begin
                win_found = 1'b1;
                win_idx   = PW'(i);
            end
        end
    end

    // Grant is suppressed during reset so a client never dequeues a request
    // that the reset edge is about to throw away.
    assign do_grant = reset_n && can_issue && win_found;

    always_comb begin
        grant    = '0;
        sel_hdr  = '0;
        sel_data = '0;
        for (int i = 0; i < N_WRITERS; i++) begin
            if (PW'(i) == win_idx) begin
                grant[i] = do_grant;
                sel_hdr  = req_hdr[i*HDR_BITS +: HDR_BITS];
                sel_data = req_data[i*DATA_BITS +: DATA_BITS];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rr_ptr   <= '0;
            tx_valid <= 1'b0;
            tx_hdr   <= '0;
            tx_data  <= '0;
        end else begin
            tx_valid <= do_grant;
            if (do_grant) begin
                rr_ptr  <= (win_idx == PW'(N_WRITERS - 1)) ? '0 : win_idx + 1'b1;
                tx_hdr  <= sel_hdr;
                tx_data <= sel_data;
            end
        end
    end

    // Credit counter. can_issue already blocks grants at the ceiling, so
    // only the underflow side needs guarding here.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            outstanding   <= '0;
            rsp_underflow <= 1'b0;
        end else if (do_grant && !wr_rsp_valid) begin
            outstanding <= outstanding + 1'b1;
        end else if (!do_grant && wr_rsp_valid) begin
            if (outstanding == '0) begin
                rsp_underflow <= 1'b1;
            end else begin
                outstanding <= outstanding - 1'b1;
            end
        end
    end

endmodule
